// File: rtl/axi4s_deframer_v2.sv
// AXI4-Stream byte deframer: START/STOP/ESCAPE stripping, length limit, abort and error flag on tuser.
// Frame counters are built only when DEFRAMER_STATS_EN is defined; otherwise the stat ports read zero.
module axi4s_deframer_v2 #(
    parameter logic [7:0]  ESCAPE_BYTE   = 8'h7F,
    parameter logic [7:0]  START_BYTE    = 8'h7D,
    parameter logic [7:0]  STOP_BYTE     = 8'h7E,
    parameter logic [7:0]  ESC_XOR       = 8'h00,
    parameter int unsigned MAX_FRAME_LEN = 1024
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        target_tvalid,
    output logic        target_tready,
    input  logic [7:0]  target_tdata,
    output logic        initiator_tvalid,
    input  logic        initiator_tready,
    output logic [7:0]  initiator_tdata,
    output logic        initiator_tlast,
    output logic        initiator_tuser,
    output logic [31:0] stat_frames_ok,
    output logic [31:0] stat_frames_err
);

    localparam logic [15:0] MAX_LEN = 16'(MAX_FRAME_LEN);

    typedef enum logic [1:0] {IDLE, DATA, ESC, DISCARD} state_t;

    state_t      state_reg, state_next;
    logic [7:0]  hold_reg;
    logic        hold_valid_reg;
    logic [15:0] len_reg;
    logic        skip_reg, skip_next;
    logic        out_valid_reg;
    logic [7:0]  out_data_reg;
    logic        out_last_reg;
    logic        out_user_reg;

    logic        accept;
    logic        is_start, is_stop, is_esc;
    logic        is_payload;
    logic        at_max;
    logic [7:0]  decoded;

    logic        push, push_last, push_user;
    logic        hold_load, hold_clear, len_clear;

    assign target_tready    = !out_valid_reg || initiator_tready;
    assign accept           = target_tvalid && target_tready;
    assign is_start         = target_tdata == START_BYTE;
    assign is_stop          = target_tdata == STOP_BYTE;
    assign is_esc           = target_tdata == ESCAPE_BYTE;
    assign decoded          = (state_reg == ESC) ? (target_tdata ^ ESC_XOR) : target_tdata;
    assign is_payload       = accept && ((state_reg == ESC) ||
                              (state_reg == DATA && !is_start && !is_stop && !is_esc));
    assign at_max           = len_reg == MAX_LEN;

    assign initiator_tvalid = out_valid_reg;
    assign initiator_tdata  = out_data_reg;
    assign initiator_tlast  = out_last_reg;
    assign initiator_tuser  = out_user_reg;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_reg <= IDLE;
            skip_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            skip_reg  <= skip_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (accept) begin
            case (state_reg)
                IDLE: begin
                    if (is_start) state_next = DATA;
                end
                DATA: begin
                    if (is_stop)                 state_next = IDLE;
                    else if (is_esc)             state_next = ESC;
                    else if (!is_start && at_max) state_next = DISCARD;
                end
                ESC: begin
                    state_next = at_max ? DISCARD : DATA;
                end
                DISCARD: begin
                    if (!skip_reg) begin
                        if (is_start)     state_next = DATA;
                        else if (is_stop) state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        push       = 1'b0;
        push_last  = 1'b0;
        push_user  = 1'b0;
        hold_load  = 1'b0;
        hold_clear = 1'b0;
        len_clear  = 1'b0;
        skip_next  = skip_reg;
        if (accept) begin
            case (state_reg)
                IDLE: begin
                    if (is_start) begin
                        len_clear  = 1'b1;
                        hold_clear = 1'b1;
                    end
                end
                DATA: begin
                    if (is_start) begin
                        // START inside a frame aborts the pending frame and opens a new one
                        push       = hold_valid_reg;
                        push_last  = 1'b1;
                        push_user  = 1'b1;
                        len_clear  = 1'b1;
                        hold_clear = 1'b1;
                    end else if (is_stop) begin
                        push       = hold_valid_reg;
                        push_last  = 1'b1;
                        hold_clear = 1'b1;
                    end
                end
                DISCARD: begin
                    if (skip_reg) begin
                        skip_next = 1'b0;
                    end else if (is_start) begin
                        len_clear  = 1'b1;
                        hold_clear = 1'b1;
                    end else if (is_esc) begin
                        skip_next = 1'b1;
                    end
                end
                default: ;
            endcase

            if (is_payload) begin
                push = hold_valid_reg;
                if (at_max) begin
                    push_last  = 1'b1;
                    push_user  = 1'b1;
                    hold_clear = 1'b1;
                end else begin
                    hold_load = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            hold_reg       <= 8'd0;
            hold_valid_reg <= 1'b0;
            len_reg        <= 16'd0;
        end else begin
            if (hold_load) begin
                hold_reg       <= decoded;
                hold_valid_reg <= 1'b1;
            end else if (hold_clear) begin
                hold_valid_reg <= 1'b0;
            end
            if (len_clear)      len_reg <= 16'd0;
            else if (hold_load) len_reg <= len_reg + 16'd1;
        end
    end

    // A push always fits: input is only accepted when the output stage is empty or draining.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= 8'd0;
            out_last_reg  <= 1'b0;
            out_user_reg  <= 1'b0;
        end else if (push) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= hold_reg;
            out_last_reg  <= push_last;
            out_user_reg  <= push_user;
        end else if (initiator_tready) begin
            out_valid_reg <= 1'b0;
        end
    end

`ifdef DEFRAMER_STATS_EN
    logic [31:0] frames_ok_reg;
    logic [31:0] frames_err_reg;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            frames_ok_reg  <= 32'd0;
            frames_err_reg <= 32'd0;
        end else if (push && push_last) begin
            if (push_user) frames_err_reg <= frames_err_reg + 32'd1;
            else           frames_ok_reg  <= frames_ok_reg + 32'd1;
        end
    end

    assign stat_frames_ok  = frames_ok_reg;
    assign stat_frames_err = frames_err_reg;
`else
    assign stat_frames_ok  = 32'd0;
    assign stat_frames_err = 32'd0;
`endif

endmodule

// File: tb/tb_axi4s_deframer_v2.sv
// Scoreboard bench for axi4s_deframer_v2 built with ESC_XOR=8'h20 and MAX_FRAME_LEN=4.
module tb_axi4s_deframer_v2;

    localparam logic [7:0] XMASK  = 8'h20;
    localparam int         MAXLEN = 4;
`ifdef DEFRAMER_STATS_EN
    localparam logic [31:0] STAT_MASK = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] STAT_MASK = 32'h0;
`endif

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        target_tvalid = 1'b0;
    logic        target_tready;
    logic [7:0]  target_tdata = 8'h00;
    logic        initiator_tvalid;
    logic        initiator_tready = 1'b0;
    logic [7:0]  initiator_tdata;
    logic        initiator_tlast;
    logic        initiator_tuser;
    logic [31:0] stat_frames_ok;
    logic [31:0] stat_frames_err;

    always #5 aclk = ~aclk;

    axi4s_deframer_v2 #(
        .ESCAPE_BYTE  (8'h7F),
        .START_BYTE   (8'h7D),
        .STOP_BYTE    (8'h7E),
        .ESC_XOR      (XMASK),
        .MAX_FRAME_LEN(MAXLEN)
    ) dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .target_tvalid   (target_tvalid),
        .target_tready   (target_tready),
        .target_tdata    (target_tdata),
        .initiator_tvalid(initiator_tvalid),
        .initiator_tready(initiator_tready),
        .initiator_tdata (initiator_tdata),
        .initiator_tlast (initiator_tlast),
        .initiator_tuser (initiator_tuser),
        .stat_frames_ok  (stat_frames_ok),
        .stat_frames_err (stat_frames_err)
    );

    typedef logic [7:0] byte_q_t[$];

    int          checks = 0;
    int          errors = 0;
    int          cycle = 0;
    int          wait_cycles = 0;
    int          exp_ok = 0;
    int          exp_err = 0;
    logic [9:0]  exp_q[$];
    int          pop_cycles[$];
    bit          rand_ready = 1'b0;
    bit          fixed_ready = 1'b0;
    bit          use_model = 1'b0;

    int          m_state = 0;
    logic [7:0]  m_hold = 8'h00;
    bit          m_hv = 1'b0;
    int          m_len = 0;
    bit          m_skip = 1'b0;

    always @(posedge aclk) cycle++;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] exp_stat(input int v);
        return 32'(v) & STAT_MASK;
    endfunction

    // Output monitor: compares every transferred beat against the scoreboard and checks stall stability.
    task automatic mon_loop();
        bit         stall = 1'b0;
        logic [9:0] held = '0;
        logic [9:0] got;
        logic [9:0] exp;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                stall = 1'b0;
            end else begin
                got = {initiator_tuser, initiator_tlast, initiator_tdata};
                if (stall) begin
                    checks++;
                    if (initiator_tvalid !== 1'b1 || got !== held) begin
                        errors++;
                        $display("FAIL stall_stable: got valid=%b user/last/data=%h required valid=1 %h",
                                 initiator_tvalid, got, held);
                    end
                end
                if (initiator_tvalid && initiator_tready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_beat: got %h required no beat", got);
                    end else begin
                        exp = exp_q.pop_front();
                        if (got !== exp) begin
                            errors++;
                            $display("FAIL beat: got user/last/data=%h required %h", got, exp);
                        end
                    end
                    pop_cycles.push_back(cycle);
                end
                stall = initiator_tvalid && !initiator_tready;
                held  = got;
            end
        end
    endtask

    task automatic ready_loop();
        forever begin
            @(posedge aclk);
            #3;
            initiator_tready = rand_ready ? 1'($urandom_range(0, 1)) : fixed_ready;
        end
    endtask

    task automatic model_payload(input logic [7:0] d);
        if (m_len == MAXLEN) begin
            if (m_hv) begin
                exp_q.push_back({1'b1, 1'b1, m_hold});
                exp_err++;
            end
            m_hv    = 1'b0;
            m_state = 3;
        end else begin
            if (m_hv) exp_q.push_back({1'b0, 1'b0, m_hold});
            m_hold = d;
            m_hv   = 1'b1;
            m_len++;
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        case (m_state)
            0: if (b == 8'h7D) begin m_state = 1; m_len = 0; m_hv = 1'b0; end
            1: begin
                if (b == 8'h7D) begin
                    if (m_hv) begin exp_q.push_back({1'b1, 1'b1, m_hold}); exp_err++; end
                    m_len = 0;
                    m_hv  = 1'b0;
                end else if (b == 8'h7E) begin
                    if (m_hv) begin exp_q.push_back({1'b0, 1'b1, m_hold}); exp_ok++; end
                    m_hv    = 1'b0;
                    m_state = 0;
                end else if (b == 8'h7F) begin
                    m_state = 2;
                end else begin
                    model_payload(b);
                end
            end
            2: begin
                m_state = 1;
                model_payload(b ^ XMASK);
            end
            default: begin
                if (m_skip)             m_skip = 1'b0;
                else if (b == 8'h7D)    begin m_state = 1; m_len = 0; m_hv = 1'b0; end
                else if (b == 8'h7E)    m_state = 0;
                else if (b == 8'h7F)    m_skip = 1'b1;
            end
        endcase
    endtask

    // Called at posedge+1; holds the beat until it is accepted at a rising edge.
    task automatic send_byte(input logic [7:0] b);
        int   n = 0;
        logic rdy;
        target_tvalid = 1'b1;
        target_tdata  = b;
        if (use_model) model_byte(b);
        forever begin
            @(negedge aclk);
            rdy = target_tready;
            @(posedge aclk);
            #1;
            if (rdy) break;
            n++;
            wait_cycles++;
            if (n > 500) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: byte %h not accepted after %0d cycles, required acceptance", b, n);
                break;
            end
        end
        target_tvalid = 1'b0;
    endtask

    task automatic send_q(input byte_q_t bq);
        foreach (bq[i]) send_byte(bq[i]);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || initiator_tvalid) && n < 3000) begin
            @(posedge aclk);
            #1;
            n++;
        end
        repeat (2) @(posedge aclk);
        #1;
        checks++;
        if (exp_q.size() != 0 || initiator_tvalid) begin
            errors++;
            $display("FAIL %s_drain: got %0d beats outstanding valid=%b required 0 and valid=0",
                     name, exp_q.size(), initiator_tvalid);
        end
    endtask

    task automatic set_ready(input bit r);
        rand_ready  = 1'b0;
        fixed_ready = r;
        @(posedge aclk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({initiator_tvalid, initiator_tdata, initiator_tlast, initiator_tuser} !== 11'd0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b data=%h last=%b user=%b required all 0",
                     initiator_tvalid, initiator_tdata, initiator_tlast, initiator_tuser);
        end
        checks++;
        if (stat_frames_ok !== 32'd0 || stat_frames_err !== 32'd0) begin
            errors++;
            $display("FAIL reset_stats: got ok=%0d err=%0d required 0 0", stat_frames_ok, stat_frames_err);
        end
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        set_ready(1'b1);
        checks++;
        if (target_tready !== 1'b1) begin
            errors++;
            $display("FAIL reset_tready: got %b required 1", target_tready);
        end
        $display("test_reset done");
    endtask

    task automatic test_basic();
        byte_q_t bq;
        exp_q.push_back({2'b00, 8'h11});
        exp_q.push_back({2'b00, 8'h22});
        exp_q.push_back({2'b01, 8'h33});
        exp_ok += 1;
        bq = {8'h33, 8'h7E, 8'h7D, 8'h11, 8'h22, 8'h33, 8'h7E};
        send_q(bq);
        wait_drain("basic");
        checks++;
        if (stat_frames_ok !== exp_stat(exp_ok) || stat_frames_err !== exp_stat(exp_err)) begin
            errors++;
            $display("FAIL basic_stats: got ok=%0d err=%0d required %0d %0d",
                     stat_frames_ok, stat_frames_err, exp_stat(exp_ok), exp_stat(exp_err));
        end
        $display("test_basic done");
    endtask

    task automatic test_escape();
        byte_q_t bq;
        exp_q.push_back({2'b00, 8'h7E});
        exp_q.push_back({2'b00, 8'h7D});
        exp_q.push_back({2'b01, 8'h44});
        exp_ok += 1;
        bq = {8'h7D, 8'h7F, 8'h5E, 8'h7F, 8'h5D, 8'h44, 8'h7E};
        send_q(bq);
        wait_drain("escape");
        checks++;
        if (stat_frames_ok !== exp_stat(exp_ok) || stat_frames_err !== exp_stat(exp_err)) begin
            errors++;
            $display("FAIL escape_stats: got ok=%0d err=%0d required %0d %0d",
                     stat_frames_ok, stat_frames_err, exp_stat(exp_ok), exp_stat(exp_err));
        end
        $display("test_escape done");
    endtask

    task automatic test_overlength();
        byte_q_t bq;
        // exactly MAX_FRAME_LEN bytes is still a good frame
        exp_q.push_back({2'b00, 8'hC1});
        exp_q.push_back({2'b00, 8'hC2});
        exp_q.push_back({2'b00, 8'hC3});
        exp_q.push_back({2'b01, 8'hC4});
        // one byte more: truncated with error; escaped STOP inside the discard is skipped
        exp_q.push_back({2'b00, 8'h01});
        exp_q.push_back({2'b00, 8'h02});
        exp_q.push_back({2'b00, 8'h03});
        exp_q.push_back({2'b11, 8'h04});
        exp_q.push_back({2'b01, 8'hAA});
        exp_ok  += 2;
        exp_err += 1;
        bq = {8'h7D, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'h7E,
              8'h7D, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h7F, 8'h7E, 8'h06, 8'h7E,
              8'h7D, 8'hAA, 8'h7E};
        send_q(bq);
        wait_drain("overlength");
        checks++;
        if (stat_frames_ok !== exp_stat(exp_ok) || stat_frames_err !== exp_stat(exp_err)) begin
            errors++;
            $display("FAIL overlength_stats: got ok=%0d err=%0d required %0d %0d",
                     stat_frames_ok, stat_frames_err, exp_stat(exp_ok), exp_stat(exp_err));
        end
        $display("test_overlength done");
    endtask

    task automatic test_abort();
        byte_q_t bq;
        exp_q.push_back({2'b00, 8'h10});
        exp_q.push_back({2'b11, 8'h20});
        exp_q.push_back({2'b01, 8'h30});
        exp_ok  += 1;
        exp_err += 1;
        bq = {8'h7D, 8'h10, 8'h20, 8'h7D, 8'h30, 8'h7E, 8'h7D, 8'h7E};
        send_q(bq);
        wait_drain("abort");
        checks++;
        if (stat_frames_ok !== exp_stat(exp_ok) || stat_frames_err !== exp_stat(exp_err)) begin
            errors++;
            $display("FAIL abort_stats: got ok=%0d err=%0d required %0d %0d",
                     stat_frames_ok, stat_frames_err, exp_stat(exp_ok), exp_stat(exp_err));
        end
        $display("test_abort done");
    endtask

    task automatic test_back_to_back();
        byte_q_t bq;
        int      base;
        base        = pop_cycles.size();
        wait_cycles = 0;
        exp_q.push_back({2'b00, 8'hA1});
        exp_q.push_back({2'b00, 8'hA2});
        exp_q.push_back({2'b01, 8'hA3});
        exp_ok += 1;
        bq = {8'h7D, 8'hA1, 8'hA2, 8'hA3, 8'h7E};
        send_q(bq);
        wait_drain("back_to_back");
        checks++;
        if (wait_cycles != 0) begin
            errors++;
            $display("FAIL b2b_input_stalls: got %0d stall cycles required 0", wait_cycles);
        end
        checks++;
        if (pop_cycles.size() != base + 3) begin
            errors++;
            $display("FAIL b2b_beats: got %0d beats required 3", pop_cycles.size() - base);
        end else if (pop_cycles[base + 1] - pop_cycles[base] != 1 ||
                     pop_cycles[base + 2] - pop_cycles[base + 1] != 1) begin
            errors++;
            $display("FAIL b2b_spacing: got gaps %0d %0d required 1 1",
                     pop_cycles[base + 1] - pop_cycles[base], pop_cycles[base + 2] - pop_cycles[base + 1]);
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_backpressure();
        logic [7:0] b;
        int         n;
        m_state    = 0;
        m_hv       = 1'b0;
        m_len      = 0;
        m_skip     = 1'b0;
        use_model  = 1'b1;
        rand_ready = 1'b1;
        for (int f = 0; f < 200; f++) begin
            if ($urandom_range(0, 3) == 0) send_byte(8'($urandom_range(0, 8'h7C)));
            send_byte(8'h7D);
            n = $urandom_range(0, 6);
            for (int k = 0; k < n; k++) begin
                b = 8'($urandom);
                if ($urandom_range(0, 11) == 0) send_byte(8'h7D);
                if (b == 8'h7D || b == 8'h7E || b == 8'h7F || $urandom_range(0, 7) == 0) begin
                    send_byte(8'h7F);
                    send_byte(b ^ XMASK);
                end else begin
                    send_byte(b);
                end
            end
            send_byte(8'h7E);
        end
        use_model = 1'b0;
        set_ready(1'b1);
        wait_drain("backpressure");
        checks++;
        if (stat_frames_ok !== exp_stat(exp_ok) || stat_frames_err !== exp_stat(exp_err)) begin
            errors++;
            $display("FAIL backpressure_stats: got ok=%0d err=%0d required %0d %0d",
                     stat_frames_ok, stat_frames_err, exp_stat(exp_ok), exp_stat(exp_err));
        end
        $display("test_backpressure done");
    endtask

    task automatic test_reset_midframe();
        byte_q_t bq;
        set_ready(1'b0);
        bq = {8'h7D, 8'h55, 8'h66};
        send_q(bq);
        aresetn = 1'b0;
        #2;
        checks++;
        if ({initiator_tvalid, initiator_tdata, initiator_tlast, initiator_tuser} !== 11'd0) begin
            errors++;
            $display("FAIL midreset_outputs: got valid=%b data=%h last=%b user=%b required all 0",
                     initiator_tvalid, initiator_tdata, initiator_tlast, initiator_tuser);
        end
        checks++;
        if (stat_frames_ok !== 32'd0 || stat_frames_err !== 32'd0) begin
            errors++;
            $display("FAIL midreset_stats: got ok=%0d err=%0d required 0 0", stat_frames_ok, stat_frames_err);
        end
        exp_q.delete();
        exp_ok  = 0;
        exp_err = 0;
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        set_ready(1'b1);
        exp_q.push_back({2'b01, 8'h77});
        exp_ok += 1;
        bq = {8'h7D, 8'h77, 8'h7E};
        send_q(bq);
        wait_drain("midreset");
        checks++;
        if (stat_frames_ok !== exp_stat(exp_ok) || stat_frames_err !== exp_stat(exp_err)) begin
            errors++;
            $display("FAIL midreset_after_stats: got ok=%0d err=%0d required %0d %0d",
                     stat_frames_ok, stat_frames_err, exp_stat(exp_ok), exp_stat(exp_err));
        end
        $display("test_reset_midframe done");
    endtask

    initial begin
        fork
            mon_loop();
            ready_loop();
        join_none
        test_reset();
        test_basic();
        test_escape();
        test_overlength();
        test_abort();
        test_back_to_back();
        test_backpressure();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
